// File: rtl/ring_ctrl_pkg.sv
// Shared types and encodings for the ring register command sequencer.
package ring_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Ring register mode encoding
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Command opcode encoding
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ROTL = 2'b01;
  localparam logic [1:0] OP_ROTR = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Opposite rotate direction (only left/right are meaningful inputs)
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return (d == MODE_LEFT) ? MODE_RIGHT : MODE_LEFT;
  endfunction

endpackage

// File: rtl/ring_step_calc.sv
// Rotate amount normalisation: reduces amt modulo N into direction and step
// count. With RING_CTRL_SHORTPATH_EN defined, rotations longer than N/2 are
// replaced by the shorter rotation in the opposite direction.
module ring_step_calc
  import ring_ctrl_pkg::*;
#(
  parameter int unsigned N  = 69,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic [1:0]    op,
  input  logic [CW-1:0] amt,
  output logic [1:0]    dir,
  output logic [CW-1:0] steps,
  output logic          zero
);

  localparam int unsigned EW = CW + 1;

  logic [EW-1:0] amt_x;
  logic [CW-1:0] eff;

  // One conditional subtract suffices since 2^CW < 2N
  always_comb begin
    amt_x = EW'(amt);
    eff   = (amt_x >= EW'(N)) ? CW'(amt_x - EW'(N)) : amt;
    dir   = (op == OP_ROTR) ? MODE_RIGHT : MODE_LEFT;
    steps = eff;
`ifdef RING_CTRL_SHORTPATH_EN
    if (EW'(eff) > EW'(N / 2)) begin
      dir   = reverse_dir(dir);
      steps = CW'(EW'(N) - EW'(eff));
    end
`endif
    zero  = (op == OP_NOP) || ((op != OP_LOAD) && (eff == '0));
  end

endmodule

// File: rtl/ring_shift_ctrl.sv
// Command sequencer for the N-bit ring register: turns one load/rotate
// command into a per-cycle mode sequence and pulses done on completion.
// Optional macro RING_CTRL_SHORTPATH_EN selects shortest-path rotation.
module ring_shift_ctrl
  import ring_ctrl_pkg::*;
#(
  parameter int unsigned N  = 69,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_amt,
  input  logic [N-1:0]  cmd_data,
  output logic [1:0]    reg_mode,
  output logic [N-1:0]  reg_data_in,
  output logic          busy,
  output logic          done
);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [N-1:0]  data_d;
  logic [1:0]    mode_d;
  logic          busy_d, ready_d, done_d;

  logic [1:0]    calc_dir;
  logic [CW-1:0] calc_steps;
  logic          calc_zero;

  ring_step_calc #(
    .N  (N),
    .CW (CW)
  ) u_calc (
    .op    (cmd_op),
    .amt   (cmd_amt),
    .dir   (calc_dir),
    .steps (calc_steps),
    .zero  (calc_zero)
  );

  // Next-state, counter, latches, and Moore output decode of the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = reg_data_in;
    mode_d  = MODE_HOLD;
    busy_d  = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op == OP_LOAD) begin
            data_d  = cmd_data;
            state_d = LOAD;
          end else if (calc_zero) begin
            state_d = DONE;
          end else begin
            dir_d   = calc_dir;
            cnt_d   = calc_steps;
            state_d = SHIFT;
          end
        end
      end
      LOAD: state_d = DONE;
      SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE:  ready_d = 1'b1;
      LOAD:  begin mode_d = MODE_LOAD; busy_d = 1'b1; end
      SHIFT: begin mode_d = dir_d;     busy_d = 1'b1; end
      DONE:  begin done_d = 1'b1;      busy_d = 1'b1; end
      default: ready_d = 1'b1;
    endcase
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= MODE_HOLD;
      reg_data_in <= '0;
      reg_mode    <= MODE_HOLD;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      reg_data_in <= data_d;
      reg_mode    <= mode_d;
      busy        <= busy_d;
      done        <= done_d;
      cmd_ready   <= ready_d;
    end
  end

endmodule

// File: tb/tb_ring_shift_ctrl.sv
// Bench for ring_shift_ctrl driving a ring register; directed and random
// commands checked against a queue-based behavioural model.
module tb_ring_shift_ctrl;
  import ring_ctrl_pkg::*;

  localparam int unsigned N  = 69;
  localparam int unsigned CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] cmd_amt = '0;
  logic [N-1:0]  cmd_data = '0;
  logic [1:0]    reg_mode;
  logic [N-1:0]  reg_data_in;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ring_shift_ctrl #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_amt     (cmd_amt),
    .cmd_data    (cmd_data),
    .reg_mode    (reg_mode),
    .reg_data_in (reg_data_in),
    .busy        (busy),
    .done        (done)
  );

  // Ring register driven by the controller
  logic [N-1:0] ring;
  always @(posedge clk) begin
    if (rst) ring <= '0;
    else begin
      case (reg_mode)
        2'b01: ring <= {ring[N-2:0], ring[N-1]};
        2'b10: ring <= {ring[0], ring[N-1:1]};
        2'b11: ring <= reg_data_in;
        default: ;
      endcase
    end
  end

  int tests = 0;
  int fails = 0;
  int n_acc_host = 0;
  int n_acc_model = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rot(input logic [N-1:0] v, input bit left, input int k);
    if (k == 0) return v;
    if (left) return (v << k) | (v >> (N - k));
    return (v >> k) | (v << (N - k));
  endfunction

  // Behavioural model: each entry is {done, mode} for one future cycle
  logic [2:0]   mq[$];
  logic [2:0]   m_cur = 3'b000;
  bit           m_busy = 1'b0;
  bit           m_valid = 1'b0;
  logic [N-1:0] m_final = '0;
  logic [N-1:0] m_data = '0;
  int           m_eff, m_s;
  bit           m_left, m_sleft;

  always @(posedge clk) begin : model
    if (rst) begin
      mq.delete();
      m_cur = 3'b000; m_busy = 1'b0; m_final = '0; m_data = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (!m_busy && cmd_valid) begin
        n_acc_model++;
        m_eff  = int'(cmd_amt);
        if (m_eff >= int'(N)) m_eff = m_eff - int'(N);
        m_left = (cmd_op == 2'b01);
        case (cmd_op)
          2'b11: begin
            mq.push_back(3'b011);
            mq.push_back(3'b100);
            m_data  = cmd_data;
            m_final = cmd_data;
          end
          2'b01, 2'b10: begin
            m_s = m_eff; m_sleft = m_left;
`ifdef RING_CTRL_SHORTPATH_EN
            if (m_eff > int'(N) / 2) begin m_s = int'(N) - m_eff; m_sleft = !m_left; end
`endif
            for (int i = 0; i < m_s; i++) mq.push_back(m_sleft ? 3'b001 : 3'b010);
            mq.push_back(3'b100);
            m_final = rot(m_final, m_left, m_eff);
          end
          default: mq.push_back(3'b100);
        endcase
      end
      if (mq.size() > 0) begin m_cur = mq.pop_front(); m_busy = 1'b1; end
      else begin m_cur = 3'b000; m_busy = 1'b0; end
    end
  end

  // Compare process: every cycle once the model is synchronised by reset
  always @(negedge clk) begin
    if (m_valid) begin
      chk("reg_mode",    N'(reg_mode),  N'(m_cur[1:0]));
      chk("done",        N'(done),      N'(m_cur[2]));
      chk("busy",        N'(busy),      N'(m_busy));
      chk("cmd_ready",   N'(cmd_ready), N'(!m_busy));
      chk("reg_data_in", reg_data_in,   m_data);
      if (m_cur[2]) chk("ring_result", ring, m_final);
    end
    if (done === 1'b1) n_done++;
  end

  // Present a command (called at a negedge); returns at the negedge after accept,
  // optionally waiting for done and measuring latency and shift cycles.
  task automatic issue(input logic [1:0] op, input int amt, input logic [N-1:0] data,
                       input bit wait_done, output int lat, output int nl, output int nr);
    int guard;
    lat = 0; nl = 0; nr = 0;
    cmd_op = op; cmd_amt = CW'(amt); cmd_data = data; cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    if (cmd_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout actual=not_ready required=ready at %0t", $time);
      cmd_valid = 1'b0;
      return;
    end
    n_acc_host++;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (wait_done) begin
      lat = 1;
      forever begin
        if (reg_mode == 2'b01) nl++;
        if (reg_mode == 2'b10) nr++;
        if (done === 1'b1) break;
        if (lat >= 200) begin
          tests++; fails++;
          $display("FAIL done_timeout actual=no_done required=done at %0t", $time);
          break;
        end
        @(negedge clk);
        lat++;
      end
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat, nl, nr, gap, done_before;
    logic [N-1:0] one;
    one = 1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_reg_mode",  N'(reg_mode),  '0);
    chk("rst_cmd_ready", N'(cmd_ready), N'(1));
    chk("rst_busy",      N'(busy),      '0);
    chk("rst_done",      N'(done),      '0);
    chk("rst_data",      reg_data_in,   '0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b11, 0, one, 1'b1, lat, nl, nr);
    chk("load_latency", N'(lat), N'(2));
    chk("load_ring", ring, one);

    issue(2'b01, 3, '0, 1'b1, lat, nl, nr);
    chk("rotl3_latency", N'(lat), N'(4));
    chk("rotl3_cycles",  N'(nl),  N'(3));
    chk("rotl3_ring",    ring,    69'h8);

    issue(2'b11, 0, one, 1'b1, lat, nl, nr);
    issue(2'b01, 60, '0, 1'b1, lat, nl, nr);
`ifdef RING_CTRL_SHORTPATH_EN
    chk("rotl60_cycles",  N'(nr),  N'(9));
    chk("rotl60_latency", N'(lat), N'(10));
`else
    chk("rotl60_cycles",  N'(nl),  N'(60));
    chk("rotl60_latency", N'(lat), N'(61));
`endif
    chk("rotl60_ring", ring, one << 60);

    issue(2'b10, 70, '0, 1'b1, lat, nl, nr);
    chk("rotr70_cycles",  N'(nr),  N'(1));
    chk("rotr70_latency", N'(lat), N'(2));
    chk("rotr70_ring",    ring,    one << 59);

    issue(2'b10, 69, '0, 1'b1, lat, nl, nr);
    chk("rotr69_latency", N'(lat), N'(1));
    chk("rotr69_ring",    ring,    one << 59);

    issue(2'b00, 5, '0, 1'b1, lat, nl, nr);
    chk("nop_latency", N'(lat), N'(1));

    // Reset in the middle of a 20-step rotate
    issue(2'b01, 20, '0, 1'b0, lat, nl, nr);
    repeat (4) @(negedge clk);
    done_before = n_done;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_reg_mode",  N'(reg_mode),  '0);
    chk("abort_cmd_ready", N'(cmd_ready), N'(1));
    chk("abort_busy",      N'(busy),      '0);
    chk("abort_ring",      ring,          '0);
    repeat (25) @(negedge clk);
    chk("abort_no_done", N'(n_done), N'(done_before));

    // Random back-to-back commands with cmd_valid held through busy
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        gap = $urandom_range(1, 2);
        repeat (gap) @(negedge clk);
      end
      issue(2'(($urandom_range(0, 3))), $urandom_range(0, 127),
            N'({$urandom, $urandom, $urandom}), 1'b0, lat, nl, nr);
    end
    repeat (160) @(negedge clk);

    chk("accept_count", N'(n_acc_host), N'(n_acc_model));
    chk("done_count",   N'(n_done),     N'(n_acc_host - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
